// File: rtl/unidade_votacao.sv
// unidade_votacao: day-phase vote scheduler for the werewolf game datapath.
//
// A pulse on iniciar latches the alive mask. The block then visits every
// player slot in index order and skips dead players. For each living player
// it waits for a passa pulse and tallies the vote held on voto. Once every
// slot is done it scans the tallies, one per cycle, and reports the
// eliminated player. A tie or an empty tally means no elimination.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous, active-high
//   iniciar         start a vote (honoured in OCIOSO or FIM)
//   passa           one-cycle pulse confirming the current player's vote
//   vivos           alive mask, sampled on iniciar
//   voto            target index, sampled on passa
//   jogador_atual   player whose vote is awaited
//   aguardando_voto high in ESPERA_VOTO
//   pronto          high in FIM
//   elimina_valido  result valid and untied
//   eliminado       eliminated player index (0 when not valid)
//   db_estado       state code for debug
//
// Handshake: passa is a single-cycle strobe from upstream. It is accepted
// only while the state register already holds ESPERA_VOTO. A pulse on the
// edge that enters ESPERA_VOTO is therefore not seen. There is no
// backpressure toward the producer.
module unidade_votacao #(
  parameter int N_JOGADORES = 8,
  parameter int W_IDX       = 3,
  parameter int W_CNT       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   passa,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic [W_IDX-1:0]       voto,
  output logic [W_IDX-1:0]       jogador_atual,
  output logic                   aguardando_voto,
  output logic                   pronto,
  output logic                   elimina_valido,
  output logic [W_IDX-1:0]       eliminado,
  output logic [3:0]             db_estado
);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    ZERA        = 4'd1,
    BUSCA       = 4'd2,
    ESPERA_VOTO = 4'd3,
    REGISTRA    = 4'd4,
    PROXIMO     = 4'd5,
    APURA       = 4'd6,
    FIM         = 4'd7
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [N_JOGADORES-1:0] vivos_q, vivos_d;
  logic [W_IDX-1:0]       jogador_q, jogador_d;
  logic [W_IDX-1:0]       idx_q, idx_d;
  logic [W_IDX-1:0]       voto_q, voto_d;
  logic [W_IDX-1:0]       vencedor_q, vencedor_d;
  logic [W_CNT-1:0]       max_q, max_d;
  logic                   empate_q, empate_d;
  logic                   valido_q, valido_d;
  logic [W_IDX-1:0]       eliminado_q, eliminado_d;
  logic [W_CNT-1:0]       contagem_q [N_JOGADORES];
  logic [W_CNT-1:0]       contagem_d [N_JOGADORES];
  logic [W_CNT-1:0]       cnt_atual;

  always_comb begin
    estado_d    = estado_q;
    vivos_d     = vivos_q;
    jogador_d   = jogador_q;
    idx_d       = idx_q;
    voto_d      = voto_q;
    vencedor_d  = vencedor_q;
    max_d       = max_q;
    empate_d    = empate_q;
    valido_d    = valido_q;
    eliminado_d = eliminado_q;
    contagem_d  = contagem_q;
    cnt_atual   = contagem_q[idx_q];

    case (estado_q)
      OCIOSO, FIM: begin
        if (iniciar) begin
          vivos_d  = vivos;
          estado_d = ZERA;
        end
      end
      ZERA: begin
        for (int i = 0; i < N_JOGADORES; i++) contagem_d[i] = '0;
        jogador_d  = '0;
        idx_d      = '0;
        max_d      = '0;
        vencedor_d = '0;
        empate_d   = 1'b0;
        estado_d   = BUSCA;
      end
      BUSCA: begin
        estado_d = vivos_q[jogador_q] ? ESPERA_VOTO : PROXIMO;
      end
      ESPERA_VOTO: begin
        if (passa) begin
          voto_d   = voto;
          estado_d = REGISTRA;
        end
      end
      REGISTRA: begin
        // Votes for dead or nonexistent slots are abstentions.
        if (int'(voto_q) < N_JOGADORES) begin
          if (vivos_q[voto_q]) contagem_d[voto_q] = contagem_q[voto_q] + W_CNT'(1);
        end
        estado_d = PROXIMO;
      end
      PROXIMO: begin
        if (int'(jogador_q) == N_JOGADORES - 1) begin
          idx_d    = '0;
          estado_d = APURA;
        end else begin
          jogador_d = jogador_q + W_IDX'(1);
          estado_d  = BUSCA;
        end
      end
      APURA: begin
        if (cnt_atual > max_q) begin
          max_d      = cnt_atual;
          vencedor_d = idx_q;
          empate_d   = 1'b0;
        end else if (cnt_atual == max_q && cnt_atual != '0) begin
          empate_d = 1'b1;
        end
        if (int'(idx_q) == N_JOGADORES - 1) begin
          // The result is built from this cycle's updated max/winner/tie.
          valido_d    = (max_d != '0) && !empate_d;
          eliminado_d = valido_d ? vencedor_d : '0;
          estado_d    = FIM;
        end else begin
          idx_d = idx_q + W_IDX'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      vivos_q     <= '0;
      jogador_q   <= '0;
      idx_q       <= '0;
      voto_q      <= '0;
      vencedor_q  <= '0;
      max_q       <= '0;
      empate_q    <= 1'b0;
      valido_q    <= 1'b0;
      eliminado_q <= '0;
      for (int i = 0; i < N_JOGADORES; i++) contagem_q[i] <= '0;
    end else begin
      estado_q    <= estado_d;
      vivos_q     <= vivos_d;
      jogador_q   <= jogador_d;
      idx_q       <= idx_d;
      voto_q      <= voto_d;
      vencedor_q  <= vencedor_d;
      max_q       <= max_d;
      empate_q    <= empate_d;
      valido_q    <= valido_d;
      eliminado_q <= eliminado_d;
      for (int i = 0; i < N_JOGADORES; i++) contagem_q[i] <= contagem_d[i];
    end
  end

  always_comb begin
    case (estado_q)
      OCIOSO:      db_estado = 4'd0;
      ZERA:        db_estado = 4'd1;
      BUSCA:       db_estado = 4'd2;
      ESPERA_VOTO: db_estado = 4'd3;
      REGISTRA:    db_estado = 4'd4;
      PROXIMO:     db_estado = 4'd5;
      APURA:       db_estado = 4'd6;
      FIM:         db_estado = 4'd7;
      default:     db_estado = 4'hF;
    endcase
  end

  assign jogador_atual   = jogador_q;
  assign aguardando_voto = (estado_q == ESPERA_VOTO);
  assign pronto          = (estado_q == FIM);
  assign elimina_valido  = valido_q;
  assign eliminado       = eliminado_q;

endmodule

// File: tb/tb_unidade_votacao.sv
// Directed bench for unidade_votacao (N_JOGADORES=8, W_IDX=3, W_CNT=4).
module tb_unidade_votacao;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       passa = 1'b0;
  logic [7:0] vivos = 8'h00;
  logic [2:0] voto = 3'd0;
  logic [2:0] jogador_atual;
  logic       aguardando_voto;
  logic       pronto;
  logic       elimina_valido;
  logic [2:0] eliminado;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc;
  int n_espera;
  int max_j;

  unidade_votacao #(.N_JOGADORES(8), .W_IDX(3), .W_CNT(4)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .passa(passa),
    .vivos(vivos),
    .voto(voto),
    .jogador_atual(jogador_atual),
    .aguardando_voto(aguardando_voto),
    .pronto(pronto),
    .elimina_valido(elimina_valido),
    .eliminado(eliminado),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one complete vote. Votes are packed three bits per player, with
  // player i in vts[3*i +: 3]. With spur set, spurious passa pulses are
  // driven outside ESPERA_VOTO, and each ESPERA_VOTO first sees a cycle of
  // iniciar with passa low. Cycles are counted with the iniciar edge as 1,
  // up to the edge that enters FIM.
  task automatic run_vote(input logic [7:0] v, input logic [23:0] vts, input bit spur);
    int wait_cnt;
    wait_cnt = 0;
    n_espera = 0;
    max_j    = -1;
    @(negedge clock);
    vivos   = v;
    iniciar = 1'b1;
    passa   = 1'b0;
    @(posedge clock);
    cyc = 1;
    @(negedge clock);
    iniciar = 1'b0;
    while (!pronto && cyc < 300) begin
      if (aguardando_voto) begin
        n_espera++;
        if (int'(jogador_atual) > max_j) max_j = int'(jogador_atual);
        if (spur && wait_cnt == 0) begin
          iniciar  = 1'b1;
          passa    = 1'b0;
          wait_cnt = 1;
        end else begin
          iniciar  = 1'b0;
          passa    = 1'b1;
          voto     = vts[3*jogador_atual +: 3];
          wait_cnt = 0;
        end
      end else begin
        iniciar  = 1'b0;
        wait_cnt = 0;
        passa    = spur && (db_estado == 4'd2 || db_estado == 4'd4 || db_estado == 4'd5);
        voto     = 3'($urandom_range(0, 7));
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    passa   = 1'b0;
    iniciar = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_db_estado", 32'(db_estado), 0);
    chk("rst_jogador", 32'(jogador_atual), 0);
    chk("rst_aguardando", 32'(aguardando_voto), 0);
    chk("rst_pronto", 32'(pronto), 0);
    chk("rst_valido", 32'(elimina_valido), 0);
    chk("rst_eliminado", 32'(eliminado), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // All alive, votes 3,3,3,1,1,0,3,2 -> player 3 with four votes
    run_vote(8'hFF, {3'd2, 3'd3, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3}, 1'b0);
    chk("t1_pronto", 32'(pronto), 1);
    chk("t1_cycles", 32'(cyc), 42);
    chk("t1_valido", 32'(elimina_valido), 1);
    chk("t1_eliminado", 32'(eliminado), 3);
    chk("t1_n_espera", 32'(n_espera), 8);
    repeat (3) @(negedge clock);
    chk("t1_hold_db", 32'(db_estado), 7);
    chk("t1_hold_elim", 32'(eliminado), 3);

    // Players 0..3 alive, votes 1,1,2,2 -> tie at two votes
    run_vote(8'b0000_1111, {3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd1, 3'd1}, 1'b0);
    chk("t2_pronto", 32'(pronto), 1);
    chk("t2_cycles", 32'(cyc), 34);
    chk("t2_valido", 32'(elimina_valido), 0);
    chk("t2_eliminado", 32'(eliminado), 0);
    chk("t2_max_jogador", 32'(max_j), 3);

    // Players 0,1 alive, player 0 votes dead 5, player 1 votes 0
    run_vote(8'b0000_0011, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5}, 1'b0);
    chk("t3_cycles", 32'(cyc), 30);
    chk("t3_valido", 32'(elimina_valido), 1);
    chk("t3_eliminado", 32'(eliminado), 0);

    // Nobody alive
    run_vote(8'h00, {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, 1'b0);
    chk("t4_cycles", 32'(cyc), 26);
    chk("t4_n_espera", 32'(n_espera), 0);
    chk("t4_valido", 32'(elimina_valido), 0);
    chk("t4_eliminado", 32'(eliminado), 0);

    // Spurious passa/iniciar: same result as the first vote, one extra
    // ESPERA_VOTO cycle per player
    run_vote(8'hFF, {3'd2, 3'd3, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3}, 1'b1);
    chk("t5_cycles", 32'(cyc), 50);
    chk("t5_n_espera", 32'(n_espera), 16);
    chk("t5_valido", 32'(elimina_valido), 1);
    chk("t5_eliminado", 32'(eliminado), 3);

    // Abort in ESPERA_VOTO of player 4 with asynchronous reset
    @(negedge clock);
    vivos   = 8'hFF;
    iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iniciar = 1'b0;
    cyc = 0;
    while (!(aguardando_voto && jogador_atual == 3'd4) && cyc < 100) begin
      passa = aguardando_voto;
      voto  = 3'd2;
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    passa = 1'b0;
    chk("t6_reached_p4", 32'(aguardando_voto && jogador_atual == 3'd4), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_db_estado", 32'(db_estado), 0);
    chk("t6_jogador", 32'(jogador_atual), 0);
    chk("t6_aguardando", 32'(aguardando_voto), 0);
    chk("t6_pronto", 32'(pronto), 0);
    chk("t6_valido", 32'(elimina_valido), 0);
    chk("t6_eliminado", 32'(eliminado), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Fresh vote after the abort: 5,5,5,0,1,2,3,4 -> player 5
    run_vote(8'hFF, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd5, 3'd5}, 1'b0);
    chk("t7_cycles", 32'(cyc), 42);
    chk("t7_valido", 32'(elimina_valido), 1);
    chk("t7_eliminado", 32'(eliminado), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
